// File: rtl/nios_mul_seq.sv
// Sequential 32x32 multiplier that drives an external registered 16x16 multiplier, one partial product per cycle.
// Define MUL_HIGH_EN for the 4-step, 64-bit-accumulator build that honours req_hi; otherwise 3 steps, low word only.
module nios_mul_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        req_hi,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p
);

`ifdef MUL_HIGH_EN
    localparam int         ACC_W     = 64;
    localparam logic [1:0] LAST_STEP = 2'd3;
    localparam logic       HIGH_EN   = 1'b1;
`else
    localparam int         ACC_W     = 32;
    localparam logic [1:0] LAST_STEP = 2'd2;
    localparam logic       HIGH_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               live;
    logic               accept;
    logic [31:0]        src1_q;
    logic [31:0]        src2_q;
    logic               hi_q;
    logic [1:0]         step_q;
    logic               pend_q;
    logic [1:0]         pend_step_q;
    logic [ACC_W-1:0]   acc_q;

    // Partial-product weights: k0 -> 0, k1/k2 -> 16, k3 -> 32; wraps modulo the accumulator width.
    function automatic logic [ACC_W-1:0] place(input logic [31:0] p, input logic [1:0] k);
        logic [63:0] w;
        w = {32'd0, p};
        case (k)
            2'd0:    w = w;
            2'd3:    w = w << 32;
            default: w = w << 16;
        endcase
        return ACC_W'(w);
    endfunction

    function automatic logic [31:0] sel_word(input logic [ACC_W-1:0] acc, input logic hi);
        logic [63:0] wide;
        wide = 64'(acc);
        return (hi && HIGH_EN) ? wide[63:32] : wide[31:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_result = 32'd0;
        mul_en     = 1'b0;
        mul_a      = 16'd0;
        mul_b      = 16'd0;
        case (state)
            IDLE: begin
                req_ready = live;
                if (req_valid && live && !flush) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_en = 1'b1;
                mul_a  = step_q[1] ? src1_q[31:16] : src1_q[15:0];
                mul_b  = step_q[0] ? src2_q[31:16] : src2_q[15:0];
                if (step_q == LAST_STEP) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                rsp_result = sel_word(acc_q, hi_q);
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // live holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live        <= 1'b0;
            src1_q      <= 32'd0;
            src2_q      <= 32'd0;
            hi_q        <= 1'b0;
            step_q      <= 2'd0;
            pend_q      <= 1'b0;
            pend_step_q <= 2'd0;
            acc_q       <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                src1_q <= req_src1;
                src2_q <= req_src2;
                hi_q   <= req_hi;
                step_q <= 2'd0;
                acc_q  <= '0;
            end else begin
                if (mul_en) begin
                    step_q <= step_q + 2'd1;
                end
                if (pend_q && !flush) begin
                    acc_q <= acc_q + place(mul_p, pend_step_q);
                end
            end
            // A flushed step never gets its product accumulated.
            pend_q      <= mul_en && !flush;
            pend_step_q <= step_q;
        end
    end

endmodule
